// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: partial-sum accumulation buffer for the 2D accelerator core.
//
// Accepts column-vector psums, read-modify-writes them into an internal array
// (per-lane saturating add in WS mode, overwrite in OS mode), clears the whole
// array with a hardware sweep, and drains an address range through a 2-entry
// valid/ready output FIFO.
//
// Ports:
//   clk, reset (async, active-low)
//   mode, in_valid/in_ready, in_addr, in_data     : accumulate input
//   clear_start                                   : zero all entries
//   drain_start, drain_base, drain_len            : start a drain (len 0 = no-op)
//   out_valid/out_ready, out_data, out_last       : drain output
//   busy, sat_flag                                : status
//
// Configuration macro: PSUM_RELU_EN -- drained lanes pass through ReLU before
// the output FIFO; memory contents are unaffected.
module psum_accum_buffer #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 2048,
  localparam int unsigned aw     = $clog2(depth),
  localparam int unsigned vw     = col * psum_bw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [aw-1:0] in_addr,
  input  logic [vw-1:0] in_data,
  input  logic          clear_start,
  input  logic          drain_start,
  input  logic [aw-1:0] drain_base,
  input  logic [aw:0]   drain_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [vw-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          sat_flag
);

  typedef enum logic [1:0] {StIdle, StClear, StDrain} state_e;

  state_e        state_q, state_d;
  logic          rdy_q;
  logic          s1_v_q, s1_v_d, s1_mode_q, s1_mode_d;
  logic [aw-1:0] s1_addr_q, s1_addr_d;
  logic [vw-1:0] s1_data_q, s1_data_d;
  logic          s2_v_q, s2_v_d, s2_mode_q, s2_mode_d;
  logic [aw-1:0] s2_addr_q, s2_addr_d;
  logic [vw-1:0] s2_data_q, s2_data_d;
  logic          fwd_q, fwd_d;
  logic [vw-1:0] fwd_data_q, fwd_data_d;
  logic [aw:0]   clr_cnt_q, clr_cnt_d;
  logic [aw-1:0] dr_addr_q, dr_addr_d;
  logic [aw:0]   dr_rem_q, dr_rem_d;
  logic          dr_inflight_q, dr_inflight_d, dr_infl_last_q, dr_infl_last_d;
  logic [vw-1:0] fifo_data_q [2];
  logic [vw-1:0] fifo_data_d [2];
  logic [1:0]    fifo_last_q, fifo_last_d;
  logic          fifo_rptr_q, fifo_rptr_d, fifo_wptr_q, fifo_wptr_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic          sat_q, sat_d;

  logic [vw-1:0] mem_q [depth];
  logic [vw-1:0] rd_q;

  logic          in_fire, pipe_busy, pop, start_dr, dr_issue, clr_we;
  logic [aw-1:0] cur_addr;
  logic [aw:0]   cur_rem;
  logic [2:0]    occ;
  logic [vw-1:0] s2_operand, s2_sum_sat, s2_result, push_data;
  logic          s2_lane_sat, s2_sat;
  logic [psum_bw-1:0] lane_a, lane_b;
  logic [psum_bw:0]   lane_sum;
  logic          mem_we, mem_re;
  logic [aw-1:0] mem_waddr, mem_raddr;
  logic [vw-1:0] mem_wdata;

  assign in_ready  = rdy_q && (state_q == StIdle) && !clear_start && !drain_start;
  assign in_fire   = in_valid && in_ready;
  assign pipe_busy = s1_v_q || s2_v_q;
  assign busy      = (state_q != StIdle) || pipe_busy;
  assign sat_flag  = sat_q;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[fifo_rptr_q];
  assign out_last  = out_valid && fifo_last_q[fifo_rptr_q];
  assign pop       = out_valid && out_ready;

  // S2 arithmetic: a back-to-back hit on the same address takes the forwarded
  // result of the previous write instead of the stale memory read.
  always_comb begin
    s2_operand  = fwd_q ? fwd_data_q : rd_q;
    s2_sum_sat  = '0;
    s2_lane_sat = 1'b0;
    lane_a      = '0;
    lane_b      = '0;
    lane_sum    = '0;
    for (int i = 0; i < int'(col); i++) begin
      lane_a   = s2_operand[i*psum_bw +: psum_bw];
      lane_b   = s2_data_q[i*psum_bw +: psum_bw];
      lane_sum = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
      // Overflow when the two top bits of the extended sum disagree.
      if (lane_sum[psum_bw] != lane_sum[psum_bw-1]) begin
        s2_lane_sat = 1'b1;
        s2_sum_sat[i*psum_bw +: psum_bw] = lane_sum[psum_bw] ?
            {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
        s2_sum_sat[i*psum_bw +: psum_bw] = lane_sum[psum_bw-1:0];
      end
    end
    s2_result = s2_mode_q ? s2_data_q : s2_sum_sat;
    s2_sat    = s2_v_q && !s2_mode_q && s2_lane_sat;
  end

  always_comb begin
    push_data = rd_q;
`ifdef PSUM_RELU_EN
    for (int i = 0; i < int'(col); i++) begin
      if (rd_q[i*psum_bw + psum_bw - 1]) push_data[i*psum_bw +: psum_bw] = '0;
    end
`else
`endif
  end

  always_comb begin
    // Accumulate pipeline
    s1_v_d     = in_fire;
    s1_addr_d  = in_fire ? in_addr : s1_addr_q;
    s1_data_d  = in_fire ? in_data : s1_data_q;
    s1_mode_d  = in_fire ? mode    : s1_mode_q;
    s2_v_d     = s1_v_q;
    s2_addr_d  = s1_addr_q;
    s2_data_d  = s1_data_q;
    s2_mode_d  = s1_mode_q;
    fwd_d      = s1_v_q && s2_v_q && (s1_addr_q == s2_addr_q);
    fwd_data_d = s2_result;

    // Drain read issue; the start cycle itself may issue so the first vector
    // appears two cycles after the pulse.
    start_dr = (state_q == StIdle) && drain_start && !clear_start;
    cur_addr = start_dr ? drain_base : dr_addr_q;
    cur_rem  = start_dr ? drain_len  : dr_rem_q;
    occ      = {1'b0, fifo_cnt_q} + {2'b00, dr_inflight_q} - {2'b00, pop};
    dr_issue = (start_dr || state_q == StDrain) && !pipe_busy &&
               (cur_rem != '0) && (occ < 3'd2);
    dr_addr_d = cur_addr;
    dr_rem_d  = cur_rem;
    if (dr_issue) begin
      dr_addr_d = (cur_addr == aw'(depth - 1)) ? '0 : cur_addr + aw'(1);
      dr_rem_d  = cur_rem - (aw+1)'(1);
    end
    dr_inflight_d  = dr_issue;
    dr_infl_last_d = dr_issue && (cur_rem == (aw+1)'(1));

    // Output FIFO
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    fifo_wptr_d = fifo_wptr_q;
    fifo_rptr_d = fifo_rptr_q;
    if (dr_inflight_q) begin
      fifo_data_d[fifo_wptr_q] = push_data;
      fifo_last_d[fifo_wptr_q] = dr_infl_last_q;
      fifo_wptr_d = ~fifo_wptr_q;
    end
    if (pop) fifo_rptr_d = ~fifo_rptr_q;
    fifo_cnt_d = fifo_cnt_q + 2'(dr_inflight_q) - 2'(pop);

    // FSM
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    sat_d     = sat_q | s2_sat;
    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end else if (drain_start) begin
          state_d = StDrain;
        end
      end
      StClear: begin
        if (!pipe_busy) begin
          if (clr_cnt_q == (aw+1)'(depth)) begin
            state_d = StIdle;
          end else begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + (aw+1)'(1);
            sat_d     = 1'b0;
          end
        end
      end
      StDrain: begin
        // Second term covers drain_len == 0.
        if ((pop && fifo_last_q[fifo_rptr_q]) ||
            (dr_rem_q == '0 && !dr_inflight_q && fifo_cnt_q == 2'd0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Memory ports; clear only writes once the pipeline is empty.
    mem_we    = s2_v_q || clr_we;
    mem_waddr = clr_we ? clr_cnt_q[aw-1:0] : s2_addr_q;
    mem_wdata = clr_we ? '0 : s2_result;
    mem_re    = dr_issue || s1_v_q;
    mem_raddr = dr_issue ? cur_addr : s1_addr_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (mem_re) rd_q <= mem_q[mem_raddr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      rdy_q          <= 1'b0;
      s1_v_q         <= 1'b0;
      s1_addr_q      <= '0;
      s1_data_q      <= '0;
      s1_mode_q      <= 1'b0;
      s2_v_q         <= 1'b0;
      s2_addr_q      <= '0;
      s2_data_q      <= '0;
      s2_mode_q      <= 1'b0;
      fwd_q          <= 1'b0;
      fwd_data_q     <= '0;
      clr_cnt_q      <= '0;
      dr_addr_q      <= '0;
      dr_rem_q       <= '0;
      dr_inflight_q  <= 1'b0;
      dr_infl_last_q <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_rptr_q    <= 1'b0;
      fifo_wptr_q    <= 1'b0;
      fifo_cnt_q     <= '0;
      sat_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rdy_q          <= 1'b1;
      s1_v_q         <= s1_v_d;
      s1_addr_q      <= s1_addr_d;
      s1_data_q      <= s1_data_d;
      s1_mode_q      <= s1_mode_d;
      s2_v_q         <= s2_v_d;
      s2_addr_q      <= s2_addr_d;
      s2_data_q      <= s2_data_d;
      s2_mode_q      <= s2_mode_d;
      fwd_q          <= fwd_d;
      fwd_data_q     <= fwd_data_d;
      clr_cnt_q      <= clr_cnt_d;
      dr_addr_q      <= dr_addr_d;
      dr_rem_q       <= dr_rem_d;
      dr_inflight_q  <= dr_inflight_d;
      dr_infl_last_q <= dr_infl_last_d;
      fifo_data_q    <= fifo_data_d;
      fifo_last_q    <= fifo_last_d;
      fifo_rptr_q    <= fifo_rptr_d;
      fifo_wptr_q    <= fifo_wptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      sat_q          <= sat_d;
    end
  end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed testbench for psum_accum_buffer.
module tb_psum_accum_buffer;
  localparam int unsigned col     = 8;
  localparam int unsigned psum_bw = 16;
  localparam int unsigned depth   = 2048;
  localparam int unsigned aw      = 11;
  localparam int unsigned vw      = col * psum_bw;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [aw-1:0] in_addr = '0;
  logic [vw-1:0] in_data = '0;
  logic          clear_start = 1'b0;
  logic          drain_start = 1'b0;
  logic [aw-1:0] drain_base = '0;
  logic [aw:0]   drain_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [vw-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          sat_flag;

  int total = 0;
  int bad   = 0;
  logic [vw-1:0] got_data [16];
  logic          got_last [16];
  int            n_got;
  int            first_cyc;

  psum_accum_buffer dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .clear_start(clear_start),
    .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [vw-1:0] rep(input logic [psum_bw-1:0] v);
    logic [vw-1:0] r;
    for (int i = 0; i < int'(col); i++) r[i*psum_bw +: psum_bw] = v;
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_timeout: busy=%0b want 0", busy);
    end
  endtask

  task automatic send(input logic [aw-1:0] a, input logic [vw-1:0] d, input logic m);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL send_ready: in_ready=%0b want 1", in_ready);
    end
    in_valid = 1'b1; in_addr = a; in_data = d; mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_clear(input logic with_drain);
    int n = 0;
    logic saw_valid = 1'b0;
    clear_start = 1'b1; drain_start = with_drain; drain_len = 4;
    @(posedge clk); #1;
    clear_start = 1'b0; drain_start = 1'b0;
    while (busy && n < 5000) begin
      if (out_valid) saw_valid = 1'b1;
      @(posedge clk); #1; n++;
    end
    total++;
    if (n != int'(depth) + 1) begin
      bad++; $display("FAIL clear_busy_cycles: got %0d want %0d", n, depth + 1);
    end
    total++;
    if (saw_valid !== 1'b0 || sat_flag !== 1'b0) begin
      bad++; $display("FAIL clear_state: out_valid_seen=%0b sat=%0b want 0 0", saw_valid, sat_flag);
    end
  endtask

  task automatic run_drain(input logic [aw-1:0] base, input logic [aw:0] len, input bit toggle);
    int cyc = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    logic [vw-1:0] prev_data = '0;
    n_got = 0; first_cyc = -1;
    drain_base = base; drain_len = len; drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    while (!done && cyc < 200) begin
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          bad++; $display("FAIL hold: valid=%0b data=%h want 1 %h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && out_ready) begin
        if (n_got < 16) begin
          got_data[n_got] = out_data; got_last[n_got] = out_last;
        end
        n_got++;
        if (out_last) done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(posedge clk); #1; cyc++;
    end
    out_ready = 1'b1;
    total++;
    if (!done) begin
      bad++; $display("FAIL drain_timeout: got %0d vectors, no out_last", n_got);
    end
    wait_idle();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid, out_last, busy, sat_flag} !== 5'b0 || out_data !== '0) begin
      bad++; $display("FAIL reset_outputs: rdy=%0b v=%0b l=%0b busy=%0b sat=%0b data=%h want 0",
                      in_ready, out_valid, out_last, busy, sat_flag, out_data);
    end
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: in_ready=%0b want 1", in_ready);
    end
  endtask

  task automatic test_ws_back_to_back();
    do_clear(1'b0);
    in_valid = 1'b1; in_addr = 5; in_data = rep(16'd3); mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready%0d: in_ready=%0b want 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();
    run_drain(5, 1, 1'b0);
    total++;
    if (n_got != 1 || got_data[0] !== rep(16'd9) || got_last[0] !== 1'b1) begin
      bad++; $display("FAIL ws_b2b: n=%0d data=%h last=%0b want 1 %h 1",
                      n_got, got_data[0], got_last[0], rep(16'd9));
    end
    total++;
    if (first_cyc != 1) begin
      bad++; $display("FAIL drain_latency: first valid at %0d want 1", first_cyc);
    end
    total++;
    if (sat_flag !== 1'b0) begin
      bad++; $display("FAIL ws_sat: sat_flag=%0b want 0", sat_flag);
    end
  endtask

  task automatic test_saturate();
    send(7, {112'h0, 16'h7fff}, 1'b0);
    send(7, {112'h0, 16'h0001}, 1'b0);
    total++;
    if (sat_flag !== 1'b1) begin
      bad++; $display("FAIL sat_set: sat_flag=%0b want 1", sat_flag);
    end
    run_drain(7, 1, 1'b0);
    total++;
    if (got_data[0] !== {112'h0, 16'h7fff}) begin
      bad++; $display("FAIL sat_value: got %h want %h", got_data[0], {112'h0, 16'h7fff});
    end
    do_clear(1'b0);
    run_drain(7, 1, 1'b0);
    total++;
    if (got_data[0] !== '0) begin
      bad++; $display("FAIL clear_value: got %h want 0", got_data[0]);
    end
  endtask

  task automatic test_os_then_ws();
    send(3, rep(16'd10), 1'b1);
    send(3, rep(16'd20), 1'b1);
    run_drain(3, 1, 1'b0);
    total++;
    if (got_data[0] !== rep(16'd20)) begin
      bad++; $display("FAIL os_overwrite: got %h want %h", got_data[0], rep(16'd20));
    end
    send(3, rep(16'hfffb), 1'b0);
    run_drain(3, 1, 1'b0);
    total++;
    if (got_data[0] !== rep(16'd15) || sat_flag !== 1'b0) begin
      bad++; $display("FAIL ws_neg_add: got %h sat=%0b want %h 0", got_data[0], sat_flag,
                      rep(16'd15));
    end
  endtask

  task automatic test_wrap_toggle();
    logic [aw-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = aw'(depth - 2 + i);
      send(a, rep(16'(100 + i)), 1'b1);
    end
    run_drain(aw'(depth - 2), 4, 1'b1);
    total++;
    if (n_got != 4) begin
      bad++; $display("FAIL wrap_count: got %0d want 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_data[i] !== rep(16'(100 + i)) || got_last[i] !== (i == 3)) begin
        bad++; $display("FAIL wrap_vec%0d: data=%h last=%0b want %h %0b", i, got_data[i],
                        got_last[i], rep(16'(100 + i)), (i == 3));
      end
    end
  endtask

  task automatic test_relu();
    logic [vw-1:0] exp;
`ifdef PSUM_RELU_EN
    exp = '0;
`else
    exp = rep(16'hfffc);
`endif
    send(9, rep(16'hfffc), 1'b1);
    run_drain(9, 1, 1'b0);
    total++;
    if (got_data[0] !== exp) begin
      bad++; $display("FAIL relu: got %h want %h", got_data[0], exp);
    end
  endtask

  task automatic test_len0();
    drain_base = 5; drain_len = 0; drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL len0_valid%0d: out_valid=%0b want 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL len0_idle: busy=%0b in_ready=%0b want 0 1", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    int cyc = 0;
    for (int i = 0; i < 8; i++) send(aw'(20 + i), rep(16'(200 + i)), 1'b1);
    out_ready = 1'b1;
    drain_base = 20; drain_len = 8; drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    while (n < 2 && cyc < 50) begin
      if (out_valid) n++;
      @(posedge clk); #1; cyc++;
    end
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, busy, in_ready} !== 4'b0) begin
      bad++; $display("FAIL mid_reset: v=%0b l=%0b busy=%0b rdy=%0b want 0", out_valid,
                      out_last, busy, in_ready);
    end
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset_ready: in_ready=%0b want 1", in_ready);
    end
    run_drain(20, 8, 1'b0);
    total++;
    if (n_got != 8) begin
      bad++; $display("FAIL restart_count: got %0d want 8", n_got);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got_data[i] !== rep(16'(200 + i)) || got_last[i] !== (i == 7)) begin
        bad++; $display("FAIL restart_vec%0d: data=%h last=%0b want %h", i, got_data[i],
                        got_last[i], rep(16'(200 + i)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ws_back_to_back();
    test_saturate();
    test_os_then_ws();
    test_wrap_toggle();
    test_relu();
    test_len0();
    do_clear(1'b1);
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_accum_buffer.md
# psum_accum_buffer

Parametrised partial-sum accumulation buffer for the 2D accelerator core: the next generation of the core's PSUM memory path. Accepts column-vector psums from the array, read-modify-writes them into an internal SRAM-style array with per-lane saturating adds (WS mode) or overwrites them (OS mode), then drains a programmable address range to the SFP/output with a valid/ready handshake. Also provides a hardware clear sweep, so software does not have to zero the buffer.

## Interface
- col, 8, lanes per vector
- psum_bw, 16, signed lane width
- depth, 2048, entries; localparam aw = $clog2(depth)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- mode  input  1  0 = WS accumulate, 1 = OS overwrite; sampled per accepted input
- in_valid  input  1  input vector valid
- in_ready  output  1  buffer can accept input
- in_addr  input  aw  target entry
- in_data  input  psum_bw*col  signed lanes, lane 0 in LSBs
- clear_start  input  1  pulse: zero all entries
- drain_start  input  1  pulse: begin drain
- drain_base  input  aw  first drained address
- drain_len  input  aw+1  number of entries (0 = no-op)
- out_valid  output  1  drained vector valid
- out_ready  input  1  consumer accepts
- out_data  output  psum_bw*col  drained vector
- out_last  output  1  final vector of drain
- busy  output  1  state != IDLE or pipeline non-empty
- sat_flag  output  1  sticky: any lane saturated since last clear

## Operation
- FSM: IDLE, CLEAR, DRAIN. Reset -> IDLE.
- in_ready = (state==IDLE) && !clear_start && !drain_start. Handshake: in_valid && in_ready.
- Accumulate pipeline (2 stages): S1 registers addr/data/mode and issues a synchronous read; S2 computes result and writes it. In WS mode, result = sat(mem + in) per lane. In OS mode, result = in.
- Saturation: signed, clamp to +2^(psum_bw-1)-1 / -2^(psum_bw-1). Any clamp sets sat_flag.
- Hazard: if S1 addr == S2 addr, S1 uses the S2 result (forwarding), not the memory output. Back-to-back hits on the same address must accumulate correctly at full rate.
- clear_start in IDLE: the pipeline drains first. Then CLEAR writes zero to addr 0..depth-1, one entry per cycle (depth cycles), clears sat_flag, and returns to IDLE.
- drain_start in IDLE: the pipeline drains first. Then DRAIN reads drain_base..drain_base+drain_len-1, with addresses wrapping modulo depth.
  - 2-entry output FIFO. A read is issued when FIFO occupancy + in-flight reads < 2, which gives full throughput under out_ready=1.
  - out_last is asserted with the final vector. Return to IDLE after out_last is accepted.
- drain_len==0: no output; return to IDLE the next cycle.
- Simultaneous clear_start and drain_start: clear wins; the drain is dropped.
- Start pulses outside IDLE are ignored.
- out_data is held stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0 during reset, 1 on the first cycle after release. out_valid=0, out_last=0, out_data=0, busy=0, sat_flag=0. State IDLE; FIFO and pipeline empty. Memory contents are undefined after reset (use clear).
- Accumulate latency: input accepted at edge k is written at edge k+2. A drain issued after busy falls sees it.
- Drain: first out_valid 2 cycles after the start pulse (pipeline empty). Then 1 vector/cycle while out_ready=1.
- Clear: busy high for depth+1 cycles after the pulse.
- Reset asserted mid-operation: FSM, pipeline, and FIFO are discarded immediately (asynchronously). In-flight writes are lost.

## Configuration
- PSUM_RELU_EN defined: drained lanes are passed through ReLU (negative -> 0) before the output FIFO. Memory contents are unaffected.
- PSUM_RELU_EN undefined: raw signed values are drained.

## Test plan
- Reset, clear, then 3 back-to-back WS inputs to addr 5 with all lanes 3, then drain base 5 len 1 -> lanes = 9, out_last=1, sat_flag=0.
- WS: addr 7 lane0 = 32767 then +1 -> lane0 = 32767, sat_flag=1. Clear -> sat_flag=0, drain of addr 7 gives 0.
- OS: write 10 then 20 to addr 3 -> drain gives 20. WS add of -5 to the same addr -> 15.
- Drain base depth-2, len 4, with out_ready toggling every cycle -> addrs depth-2, depth-1, 0, 1 in order, no duplicates or drops, out_last only on the 4th vector.
- With PSUM_RELU_EN: entry holding -4 drains as 0. Without it: drains as -4 (0xFFFC).
- Assert reset mid-drain (after 2 of 8 vectors) -> out_valid=0 immediately; in_ready=1 on the cycle after release; a new drain restarts cleanly.
